// File: rtl/bus_pkg.sv
// Shared types and slice widths for the snooping-bus arbiter.
package bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int OP_W   = 2;

    typedef enum logic [OP_W-1:0] {
        BUS_RD   = 2'b00,
        BUS_UPGR = 2'b01,
        BUS_RDX  = 2'b10,
        BUS_NON  = 2'b11
    } bus_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// Core-side request/snoop inputs and the arbitrated broadcast bus outputs.
interface bus_arbiter_if #(
    parameter int NUM_CORES = 4
);
    import bus_pkg::*;

    localparam int ID_W = $clog2(NUM_CORES);

    // Handshake: a core raises req_core and holds it (level) until its bus
    // work is done; grant is a registered one-hot answer, and while a core's
    // grant bit is high the broadcast bus carries that core's op/address/data.
    logic [NUM_CORES-1:0]        req_core;
    logic [OP_W*NUM_CORES-1:0]   core_operation;
    logic [ADDR_W*NUM_CORES-1:0] core_address;
    logic [DATA_W*NUM_CORES-1:0] core_data;
    logic [NUM_CORES-1:0]        core_cache_hit;

    logic [NUM_CORES-1:0]        grant;
    logic [OP_W-1:0]             bus_operation;
    logic [ADDR_W-1:0]           bus_address;
    logic [DATA_W-1:0]           bus_data;
    logic                        bus_valid;
    logic [ID_W-1:0]             owner_id;
    logic                        cache_hit_out;
    logic                        timeout;
    arb_state_e                  dbg_state;

    modport master (
        input  req_core, core_operation, core_address, core_data, core_cache_hit,
        output grant, bus_operation, bus_address, bus_data, bus_valid,
               owner_id, cache_hit_out, timeout, dbg_state
    );

    modport slave (
        output req_core, core_operation, core_address, core_data, core_cache_hit,
        input  grant, bus_operation, bus_address, bus_data, bus_valid,
               owner_id, cache_hit_out, timeout, dbg_state
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first set request after 'last', wrapping.
module rr_picker #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic            valid,
    output logic [ID_W-1:0] winner
);

    logic [ID_W-1:0] idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 1; i <= N; i++) begin
            idx = ID_W'((int'(last) + i) % N);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared snooping bus with a hold timeout and a
// broadcast mux that forwards the owner's operation/address/data to all snoopers.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int MAX_HOLD  = 16
) (
    input logic            clk,
    input logic            reset,
    bus_arbiter_if.master  arb
);

    localparam int ID_W   = $clog2(NUM_CORES);
    localparam int HOLD_W = $clog2(MAX_HOLD);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_OWN  = OWN;
    localparam logic [1:0] S_GAP  = GAP;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [1:0]           state_q;
    logic [NUM_CORES-1:0] grant_q;
    logic [ID_W-1:0]      owner_q;
    logic [ID_W-1:0]      last_q;
    logic [HOLD_W-1:0]    hold_q;
    logic                 timeout_q;

    logic                 pick_valid;
    logic [ID_W-1:0]      pick_id;
    logic                 owner_req;
    logic                 others_req;
    logic                 own;

    logic [OP_W-1:0]      op_slice   [NUM_CORES];
    logic [ADDR_W-1:0]    addr_slice [NUM_CORES];
    logic [DATA_W-1:0]    data_slice [NUM_CORES];

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_slice
        assign op_slice[i]   = arb.core_operation[OP_W*i +: OP_W];
        assign addr_slice[i] = arb.core_address[ADDR_W*i +: ADDR_W];
        assign data_slice[i] = arb.core_data[DATA_W*i +: DATA_W];
    end

    rr_picker #(
        .N    (NUM_CORES),
        .ID_W (ID_W)
    ) u_picker (
        .req    (arb.req_core),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_id)
    );

    assign owner_req  = arb.req_core[owner_q];
    // grant_q is one-hot on the owner in OWN, so masking it leaves only competitors.
    assign others_req = |(arb.req_core & ~grant_q);
    assign own        = (state_q == S_OWN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            last_q    <= ID_W'(NUM_CORES - 1);
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        state_q <= S_OWN;
                        grant_q <= NUM_CORES'(1) << pick_id;
                        owner_q <= pick_id;
                        last_q  <= pick_id;
                        hold_q  <= '0;
                    end
                end
                S_OWN: begin
                    if (hold_q != HOLD_LAST) begin
                        hold_q <= hold_q + 1'b1;
                    end
                    if (!owner_req) begin
                        state_q <= S_GAP;
                        grant_q <= '0;
                    end else if (hold_q == HOLD_LAST && others_req) begin
                        state_q   <= S_GAP;
                        grant_q   <= '0;
                        timeout_q <= 1'b1;
                    end
                end
                S_GAP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        arb.bus_operation = BUS_NON;
        arb.bus_address   = '0;
        arb.bus_data      = '0;
        arb.cache_hit_out = 1'b0;
        if (own) begin
            arb.bus_operation = op_slice[owner_q];
            arb.bus_address   = addr_slice[owner_q];
            arb.bus_data      = data_slice[owner_q];
            arb.cache_hit_out = |(arb.core_cache_hit & ~grant_q);
        end
    end

    assign arb.grant     = grant_q;
    assign arb.bus_valid = own;
    assign arb.owner_id  = owner_q;
    assign arb.timeout   = timeout_q;
    assign arb.dbg_state = arb_state_e'(state_q);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed sequences, a vector table and
// randomized traffic compared every cycle against a behavioural ownership model.
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int N        = 4;
    localparam int MAX_HOLD = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_arbiter_if #(.NUM_CORES(N)) ifc ();

    bus_arbiter #(
        .NUM_CORES (N),
        .MAX_HOLD  (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .arb   (ifc)
    );

    // ---------------- stimulus state ----------------
    int          total = 0;
    int          bad   = 0;
    logic [N-1:0] req_v;
    logic [N-1:0] hit_v;
    logic [1:0]   op_a   [N];
    logic [31:0]  addr_a [N];
    logic [31:0]  data_a [N];
    logic [N-1:0] exp_q [$];

    // ---------------- reference model ----------------
    int m_owner;   // -1 when nobody owns the bus
    int m_last;
    int m_held;    // owned cycles so far, counting the current one
    int m_id;
    bit m_gap;
    bit m_tout;

    typedef struct {
        logic [3:0]  hit;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_hit;
        logic [1:0]  exp_op;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_held  = 0;
        m_id    = 0;
        m_gap   = 1'b0;
        m_tout  = 1'b0;
    endfunction

    function automatic void model_edge();
        logic [N-1:0] others;
        m_tout = 1'b0;
        if (m_owner >= 0) begin
            others = req_v;
            others[m_owner] = 1'b0;
            if (!req_v[m_owner]) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end else if (m_held >= MAX_HOLD && others != 0) begin
                m_owner = -1;
                m_gap   = 1'b1;
                m_tout  = 1'b1;
            end else if (m_held < MAX_HOLD) begin
                m_held++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (req_v[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_id    = c;
                    m_held  = 1;
                    break;
                end
            end
        end
    endfunction

    task automatic check_model();
        logic [N-1:0] eg;
        logic [1:0]   eop;
        logic [31:0]  ea;
        logic [31:0]  ed;
        logic         eh;
        if (m_owner >= 0) begin
            eg  = N'(1 << m_owner);
            eop = op_a[m_owner];
            ea  = addr_a[m_owner];
            ed  = data_a[m_owner];
            eh  = |(hit_v & ~eg);
        end else begin
            eg  = '0;
            eop = 2'b11;
            ea  = '0;
            ed  = '0;
            eh  = 1'b0;
        end
        chk("m_grant",   ifc.grant,         eg);
        chk("m_op",      ifc.bus_operation, eop);
        chk("m_addr",    ifc.bus_address,   ea);
        chk("m_data",    ifc.bus_data,      ed);
        chk("m_valid",   ifc.bus_valid,     m_owner >= 0);
        chk("m_owner",   ifc.owner_id,      m_id);
        chk("m_hit",     ifc.cache_hit_out, eh);
        chk("m_timeout", ifc.timeout,       m_tout);
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply();
        for (int i = 0; i < N; i++) begin
            ifc.core_operation[2*i +: 2]  = op_a[i];
            ifc.core_address[32*i +: 32]  = addr_a[i];
            ifc.core_data[32*i +: 32]     = data_a[i];
        end
        ifc.req_core       = req_v;
        ifc.core_cache_hit = hit_v;
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic cyc();
        #1 check_model();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1 check_model();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int own_cnt, tout_cnt, tout_gap_ok, got3, bad_cycles;

        vecs[0] = '{4'b0100, 2'b10, 32'h0000_0040, 32'h1111_0000, 1'b0, 2'b10, 32'h0000_0040, 32'h1111_0000};
        vecs[1] = '{4'b0001, 2'b00, 32'h0000_1000, 32'h0000_0000, 1'b1, 2'b00, 32'h0000_1000, 32'h0000_0000};
        vecs[2] = '{4'b1000, 2'b01, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 1'b1, 2'b01, 32'hFFFF_FFFC, 32'hDEAD_BEEF};
        vecs[3] = '{4'b0000, 2'b11, 32'h0000_0000, 32'h0000_0005, 1'b0, 2'b11, 32'h0000_0000, 32'h0000_0005};
        vecs[4] = '{4'b1111, 2'b10, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 2'b10, 32'h8000_0000, 32'h7FFF_FFFF};
        vecs[5] = '{4'b0110, 2'b01, 32'h1234_5678, 32'hCAFE_F00D, 1'b1, 2'b01, 32'h1234_5678, 32'hCAFE_F00D};

        reset = 1'b0;
        req_v = '0;
        hit_v = '0;
        for (int i = 0; i < N; i++) begin
            op_a[i]   = 2'b11;
            addr_a[i] = '0;
            data_a[i] = '0;
        end
        apply();
        model_reset();
        #1;
        chk("rst_grant",   ifc.grant,         0);
        chk("rst_op",      ifc.bus_operation, 2'b11);
        chk("rst_addr",    ifc.bus_address,   0);
        chk("rst_data",    ifc.bus_data,      0);
        chk("rst_valid",   ifc.bus_valid,     0);
        chk("rst_owner",   ifc.owner_id,      0);
        chk("rst_hit",     ifc.cache_hit_out, 0);
        chk("rst_timeout", ifc.timeout,       0);
        @(negedge clk);
        reset = 1'b1;

        // ---- round robin with all four cores requesting ----
        exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000};
        req_v = 4'b1111;
        apply();
        cyc();
        for (int k = 0; k < N; k++) begin
            #1 chk("rr_grant", ifc.grant, exp_q.pop_front());
            cyc();
            req_v[k] = 1'b0;
            apply();
            #1 chk("rr_hold", ifc.grant, 1 << k);
            cyc();
            req_v[k] = 1'b1;
            apply();
            #1 chk("rr_gap_grant", ifc.grant, 0);
            chk("rr_gap_valid", ifc.bus_valid, 0);
            cyc();
            #1 chk("rr_idle_grant", ifc.grant, 0);
            cyc();
        end
        req_v = '0;
        apply();
        cyc();
        cyc();
        cyc();

        // ---- core 2 alone, BusRdX at 0x40, then mux/hit table ----
        do_reset();
        op_a[0] = 2'b00; addr_a[0] = 32'hA0; data_a[0] = 32'hA;
        op_a[1] = 2'b01; addr_a[1] = 32'hB0; data_a[1] = 32'hB;
        op_a[3] = 2'b11; addr_a[3] = 32'hD0; data_a[3] = 32'hD;
        op_a[2] = 2'b10; addr_a[2] = 32'h40; data_a[2] = 32'h1111_0000;
        req_v = 4'b0100;
        apply();
        #1 chk("c2_before_grant", ifc.grant, 0);
        cyc();
        #1;
        chk("c2_grant", ifc.grant,         4'b0100);
        chk("c2_op",    ifc.bus_operation, 2'b10);
        chk("c2_addr",  ifc.bus_address,   32'h40);
        chk("c2_owner", ifc.owner_id,      2);
        chk("c2_valid", ifc.bus_valid,     1);
        chk("c2_state", ifc.dbg_state,     OWN);
        for (int v = 0; v < 6; v++) begin
            hit_v     = vecs[v].hit;
            op_a[2]   = vecs[v].op;
            addr_a[2] = vecs[v].addr;
            data_a[2] = vecs[v].data;
            apply();
            #1;
            chk("vec_hit",  ifc.cache_hit_out, vecs[v].exp_hit);
            chk("vec_op",   ifc.bus_operation, vecs[v].exp_op);
            chk("vec_addr", ifc.bus_address,   vecs[v].exp_addr);
            chk("vec_data", ifc.bus_data,      vecs[v].exp_data);
            cyc();
        end
        req_v = '0;
        hit_v = '0;
        apply();
        cyc();
        cyc();
        cyc();

        // ---- core 0 owns: snoop hit excludes the owner ----
        do_reset();
        req_v = 4'b0001;
        apply();
        cyc();
        hit_v = 4'b0101;
        apply();
        #1 chk("hit_0101", ifc.cache_hit_out, 1);
        hit_v = 4'b0001;
        apply();
        #1 chk("hit_0001", ifc.cache_hit_out, 0);
        cyc();

        // ---- asynchronous reset while core 0 owns ----
        #3 reset = 1'b0;
        #1;
        chk("arst_grant", ifc.grant,         0);
        chk("arst_op",    ifc.bus_operation, 2'b11);
        chk("arst_valid", ifc.bus_valid,     0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        req_v = 4'b1111;
        apply();
        cyc();
        #1 chk("arst_first_win", ifc.grant, 4'b0001);
        req_v = '0;
        apply();
        cyc();
        cyc();
        cyc();

        // ---- hold timeout: core 1 holds, core 3 waits ----
        do_reset();
        req_v = 4'b0010;
        apply();
        cyc();
        req_v = 4'b1010;
        apply();
        own_cnt = 0;
        tout_cnt = 0;
        tout_gap_ok = 1;
        got3 = 0;
        for (int i = 0; i < 40 && got3 == 0; i++) begin
            #1;
            if (ifc.grant == 4'b0010) own_cnt++;
            if (ifc.timeout) begin
                tout_cnt++;
                if (ifc.grant != 0 || ifc.bus_valid) tout_gap_ok = 0;
            end
            if (ifc.grant == 4'b1000) got3 = 1;
            else cyc();
        end
        chk("to_own_cycles", own_cnt,     MAX_HOLD);
        chk("to_pulses",     tout_cnt,    1);
        chk("to_in_gap",     tout_gap_ok, 1);
        chk("to_core3",      got3,        1);
        req_v = '0;
        apply();
        cyc();
        cyc();
        cyc();

        // ---- lone owner keeps the bus indefinitely ----
        do_reset();
        req_v = 4'b0010;
        apply();
        cyc();
        bad_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (ifc.grant != 4'b0010 || ifc.timeout) bad_cycles++;
            cyc();
        end
        chk("hold100_bad_cycles", bad_cycles, 0);
        req_v = '0;
        apply();
        cyc();
        cyc();
        cyc();

        // ---- randomized traffic against the model ----
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) req_v[i] = ~req_v[i];
                op_a[i]   = 2'($urandom_range(3));
                addr_a[i] = $urandom;
                data_a[i] = $urandom;
            end
            hit_v = 4'($urandom_range(15));
            apply();
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter and broadcast multiplexer for the shared snooping bus between the per-core L1 cache subsystems. It collects `req_core` from each core and issues a one-hot `grant`. While a core owns the bus, it drives that core's operation, address and data onto the broadcast bus seen by every snooper, and returns the OR of the other cores' `cache_hit` lines to the owner. A hold-timeout guarantees forward progress when a core keeps `req_core` asserted.

## Interface
- `NUM_CORES`, 4: number of requesting cores (2..8).
- `MAX_HOLD`, 16: maximum consecutive owned cycles before forced release when another core is waiting (≥2).
- `ID_W`, `$clog2(NUM_CORES)`: owner index width (localparam).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_core`  in  NUM_CORES  per-core bus request; level, held until the core finishes.
- `core_operation`  in  2*NUM_CORES  per-core operation, core i at [2i+1:2i]: BusRd 00, BusUpgr 01, BusRdX 10, BusNoN 11.
- `core_address`  in  32*NUM_CORES  per-core address, core i at [32i+31:32i].
- `core_data`  in  32*NUM_CORES  per-core write/flush data.
- `core_cache_hit`  in  NUM_CORES  per-core snoop hit.
- `grant`  out  NUM_CORES  one-hot or zero; registered.
- `bus_operation`  out  2  broadcast operation; BusNoN when no owner.
- `bus_address`  out  32  broadcast address; 0 when no owner.
- `bus_data`  out  32  broadcast data; 0 when no owner.
- `bus_valid`  out  1  high while the OWN state is active.
- `owner_id`  out  ID_W  index of the current owner; holds the last owner when idle.
- `cache_hit_out`  out  1  OR of `core_cache_hit` excluding the owner; 0 when no owner.
- `timeout`  out  1  one-cycle pulse on forced release.

## Operation
- FSM states are IDLE, OWN and GAP.
- **IDLE**
  - `grant` = 0.
  - If any `req_core` bit is set, pick the winner round-robin: search starts at `last_owner+1` and wraps modulo NUM_CORES.
  - Register `grant[winner]`, set `owner_id` and `last_owner` to the winner, clear `hold_cnt`, and go to OWN.
- **OWN**
  - `grant` stays one-hot and `bus_valid` = 1.
  - Bus outputs are combinational muxes of the owner's `core_*` slices.
  - `hold_cnt` increments each cycle and saturates at MAX_HOLD-1.
  - If `req_core[owner]` = 0: go to GAP and deassert `grant` in the next cycle.
  - Else if `hold_cnt` = MAX_HOLD-1 and any other request is set: go to GAP and pulse `timeout` for one cycle, in the cycle GAP is entered.
  - Else: stay in OWN. With no competing request the owner keeps the bus indefinitely.
- **GAP**
  - One dead cycle: `grant` = 0, BusNoN, `bus_valid` = 0.
  - Always go to IDLE. Arbitration takes place in IDLE.
- Simultaneous requests are resolved purely by the round-robin pointer. No core wins twice in a row while another core is requesting.
- A `req_core` pulse that drops before it is granted is lost. The core must hold its request.
- If a request reasserts in the same cycle as GAP, it is evaluated in the following IDLE cycle.
- Reset, asynchronous and active-low, mid-operation:
  - FSM → IDLE, `grant` = 0, `hold_cnt` = 0, `timeout` = 0.
  - `last_owner` = NUM_CORES-1, so core 0 wins first; `owner_id` = 0.
  - Bus outputs take the no-owner values.

## Timing
- Request to grant: `req_core` sampled high in IDLE gives `grant` high at the next edge, i.e. one cycle of latency.
- Release: `req_core[owner]` low in cycle t gives `grant` low from t+1 (GAP). The earliest next grant is at t+3.
- Minimum owned interval is 1 cycle. A forced release happens after exactly MAX_HOLD cycles of OWN.
- Broadcast bus and `cache_hit_out` are combinational from registered `grant`/`owner_id` and the core inputs, so there is no added latency.
- `grant` and `timeout` are registered outputs; `bus_valid` is decoded from the state register.

## Structure
- Package `bus_pkg` holds:
  - `bus_op_e` (BUS_RD, BUS_UPGR, BUS_RDX, BUS_NON);
  - `arb_state_e` (IDLE, OWN, GAP);
  - slice-width constants (`ADDR_W` = 32, `DATA_W` = 32, `OP_W` = 2).
- Sub-module `rr_picker` is a combinational round-robin priority encoder.
  - Inputs: `req` vector and `last` pointer.
  - Outputs: `valid` and `winner`.

## Test plan
- Reset then `req_core`=4'b1111 held → grant 0001, 0010, 0100, 1000 in turn. Each core releases after 2 cycles; each hand-over has a 1-cycle GAP.
- Core 2 alone requests with BusRdX at address 0x0000_0040 → `grant`=0100 one cycle later; `bus_operation`=10 and `bus_address`=0x40 while granted; `owner_id`=2.
- Core 1 holds its request while core 3 requests, MAX_HOLD=16 → core 1 is released after 16 OWN cycles with a `timeout` pulse, then core 3 is granted.
- Core 0 owns; `core_cache_hit`=4'b0101 → `cache_hit_out`=1. With `core_cache_hit`=4'b0001 → `cache_hit_out`=0.
- Core 1 alone holds its request for 100 cycles → `grant` stays 0010 and no `timeout` occurs.
- `reset` asserted low mid-OWN → `grant`=0 and `bus_operation`=11 immediately, without a clock edge; after deassertion core 0 wins a 4'b1111 request.
